// File: rtl/vga_console_writer.sv
// Console writer: turns an ASCII byte stream into char/color map writes for the VGA bus
// controller, tracking the cursor and handling wrap, backspace, clear and hardware scroll.
module vga_console_writer #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter logic [31:0] CHAR_BASE = 32'h0000_0000,
    parameter logic [31:0] COL_BASE  = 32'h0000_1000,
    parameter logic [7:0]  BLANK     = 8'h20
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ch_valid_i,
    input  logic [7:0]              ch_data_i,
    input  logic [7:0]              color_i,
    output logic                    ch_ready_o,
    output logic                    busy_o,
    output logic [$clog2(ROWS)-1:0] cursor_row_o,
    output logic [$clog2(COLS)-1:0] cursor_col_o,
    output logic                    req_o,
    output logic                    write_enable_o,
    output logic [3:0]              mem_be_o,
    output logic [31:0]             addr_o,
    output logic [31:0]             write_data_o,
    input  logic [31:0]             read_data_i
);
    localparam int ROW_W      = $clog2(ROWS);
    localparam int COL_W      = $clog2(COLS);
    localparam int IDX_W      = $clog2(ROWS * COLS);
    localparam int WORDS      = ROWS * COLS / 4;
    localparam int ROW_WORDS  = COLS / 4;
    localparam int COPY_WORDS = WORDS - ROW_WORDS;
    localparam int CNT_W      = $clog2(WORDS);

    typedef enum logic [2:0] {IDLE, WR_CHR, WR_COL, SCR_RD, SCR_WR, CLR} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             map_sel;
    logic             clear_all;
    logic [7:0]       color_q;
    logic [31:0]      wdata_q;
    logic [IDX_W-1:0] idx;
    logic [31:0]      cell_off;
    logic [3:0]       cell_be;

    function automatic logic [31:0] word_addr(input logic sel, input logic [31:0] w);
        return (sel ? COL_BASE : CHAR_BASE) + (w << 2);
    endfunction

    assign idx      = IDX_W'(cursor_row_o) * IDX_W'(COLS) + IDX_W'(cursor_col_o);
    assign cell_off = 32'({idx[IDX_W-1:2], 2'b00});
    assign cell_be  = 4'b0001 << idx[1:0];

    assign ch_ready_o = (state == IDLE) && !rst_i;
    assign busy_o     = (state != IDLE);
    // Copy writes forward the word read in the previous cycle straight onto the bus.
    assign write_data_o = (state == SCR_WR) ? read_data_i : wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cursor_row_o   <= '0;
            cursor_col_o   <= '0;
            req_o          <= 1'b0;
            write_enable_o <= 1'b0;
            mem_be_o       <= 4'h0;
            addr_o         <= 32'h0;
            wdata_q        <= 32'h0;
            cnt            <= '0;
            map_sel        <= 1'b0;
            clear_all      <= 1'b0;
            color_q        <= 8'h0;
        end else begin
            req_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ch_valid_i) begin
                        color_q <= color_i;
                        if (ch_data_i >= 8'h20 && ch_data_i <= 8'h7E) begin
                            state          <= WR_CHR;
                            req_o          <= 1'b1;
                            write_enable_o <= 1'b1;
                            mem_be_o       <= cell_be;
                            addr_o         <= CHAR_BASE + cell_off;
                            wdata_q        <= {4{ch_data_i}};
                        end else begin
                            case (ch_data_i)
                                8'h0A: begin
                                    if (cursor_row_o == ROW_W'(ROWS - 1)) begin
                                        state          <= SCR_RD;
                                        map_sel        <= 1'b0;
                                        clear_all      <= 1'b0;
                                        cnt            <= '0;
                                        req_o          <= 1'b1;
                                        write_enable_o <= 1'b0;
                                        mem_be_o       <= 4'hF;
                                        addr_o         <= word_addr(1'b0, 32'(ROW_WORDS));
                                    end else begin
                                        cursor_col_o <= '0;
                                        cursor_row_o <= cursor_row_o + ROW_W'(1);
                                    end
                                end
                                8'h0D: cursor_col_o <= '0;
                                8'h08: begin
                                    if (cursor_col_o != '0)
                                        cursor_col_o <= cursor_col_o - COL_W'(1);
                                end
                                8'h0C: begin
                                    state          <= CLR;
                                    map_sel        <= 1'b0;
                                    clear_all      <= 1'b1;
                                    cnt            <= '0;
                                    req_o          <= 1'b1;
                                    write_enable_o <= 1'b1;
                                    mem_be_o       <= 4'hF;
                                    addr_o         <= CHAR_BASE;
                                    wdata_q        <= {4{BLANK}};
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                WR_CHR: begin
                    state   <= WR_COL;
                    req_o   <= 1'b1;
                    addr_o  <= COL_BASE + cell_off;
                    wdata_q <= {4{color_q}};
                end
                WR_COL: begin
                    if (cursor_col_o != COL_W'(COLS - 1)) begin
                        state        <= IDLE;
                        cursor_col_o <= cursor_col_o + COL_W'(1);
                    end else if (cursor_row_o != ROW_W'(ROWS - 1)) begin
                        state        <= IDLE;
                        cursor_col_o <= '0;
                        cursor_row_o <= cursor_row_o + ROW_W'(1);
                    end else begin
                        state          <= SCR_RD;
                        map_sel        <= 1'b0;
                        clear_all      <= 1'b0;
                        cnt            <= '0;
                        req_o          <= 1'b1;
                        write_enable_o <= 1'b0;
                        mem_be_o       <= 4'hF;
                        addr_o         <= word_addr(1'b0, 32'(ROW_WORDS));
                    end
                end
                SCR_RD: begin
                    state          <= SCR_WR;
                    req_o          <= 1'b1;
                    write_enable_o <= 1'b1;
                    addr_o         <= word_addr(map_sel, 32'(cnt));
                end
                SCR_WR: begin
                    req_o <= 1'b1;
                    if (cnt != CNT_W'(COPY_WORDS - 1)) begin
                        state          <= SCR_RD;
                        cnt            <= cnt + CNT_W'(1);
                        write_enable_o <= 1'b0;
                        addr_o         <= word_addr(map_sel, 32'(cnt) + 32'(ROW_WORDS + 1));
                    end else if (!map_sel) begin
                        state          <= SCR_RD;
                        map_sel        <= 1'b1;
                        cnt            <= '0;
                        write_enable_o <= 1'b0;
                        addr_o         <= word_addr(1'b1, 32'(ROW_WORDS));
                    end else begin
                        // Both maps shifted up; blank the bottom row starting with the char map.
                        state   <= CLR;
                        map_sel <= 1'b0;
                        cnt     <= CNT_W'(COPY_WORDS);
                        addr_o  <= word_addr(1'b0, 32'(COPY_WORDS));
                        wdata_q <= {4{BLANK}};
                    end
                end
                CLR: begin
                    if (cnt != CNT_W'(WORDS - 1)) begin
                        req_o  <= 1'b1;
                        cnt    <= cnt + CNT_W'(1);
                        addr_o <= word_addr(map_sel, 32'(cnt) + 32'd1);
                    end else if (!map_sel) begin
                        req_o   <= 1'b1;
                        map_sel <= 1'b1;
                        cnt     <= clear_all ? '0 : CNT_W'(COPY_WORDS);
                        addr_o  <= word_addr(1'b1, clear_all ? 32'd0 : 32'(COPY_WORDS));
                        wdata_q <= {4{color_q}};
                    end else begin
                        state        <= IDLE;
                        cursor_col_o <= '0;
                        cursor_row_o <= clear_all ? '0 : ROW_W'(ROWS - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vga_console_writer.md
Name: vga_console_writer

Overview:
- Bus master that sits directly upstream of the VGA system-bus controller and drives its req/we/be/addr/wdata port.
- Converts a byte stream of ASCII characters (valid/ready) into char-map and color-map writes.
- Maintains the cursor and handles newline, carriage return, backspace, clear-screen, line wrap and hardware scroll, so software or a UART can print text without computing addresses.

Parameters:
- COLS, 80, characters per row; must be a multiple of 4.
- ROWS, 30, rows on screen.
- CHAR_BASE, 32'h0000_0000, byte base address of char map as seen by the VGA controller.
- COL_BASE, 32'h0000_1000, byte base address of color map.
- BLANK, 8'h20, fill character for clear and scroll.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- ch_valid_i  in  1  character available
- ch_data_i  in  8  character code
- color_i  in  8  color attribute, sampled with the character
- ch_ready_o  out  1  block can accept a character
- busy_o  out  1  FSM not in IDLE
- cursor_row_o  out  $clog2(ROWS)  current row
- cursor_col_o  out  $clog2(COLS)  current column
- req_o  out  1  bus request to VGA controller
- write_enable_o  out  1  1 = write, 0 = read
- mem_be_o  out  4  byte enables
- addr_o  out  32  byte address, always word aligned
- write_data_o  out  32  write data
- read_data_i  in  32  read data, valid the cycle after a read req

Behaviour:
- Single clock. Synchronous active-high reset: clk_i, rst_i.
- Reset values:
  - req_o = 0, write_enable_o = 0, mem_be_o = 0, addr_o = 0, write_data_o = 0
  - ch_ready_o = 0 while rst_i is high, 1 the first cycle after
  - busy_o = 0, cursor = (0,0)
- Reset mid-operation aborts any copy or clear. req_o is 0 from the next cycle. Screen contents are left as is.
- Addressing:
  - Linear index idx = row*COLS + col.
  - addr_o = base + {idx[..:2], 2'b00}.
  - mem_be_o = 4'b0001 << idx[1:0].
  - write_data_o = {4{byte}}.
- Bus rules:
  - The block is the only master; no stall.
  - req_o is high for exactly one cycle per access.
  - For reads, read_data_i is captured in the cycle after the req.
- FSM states: IDLE, WR_CHR, WR_COL, SCR_RD, SCR_WR, CLR.
- IDLE: ch_ready_o = 1. A handshake (valid & ready) at cycle T latches ch_data_i and color_i, then decodes:
  - 0x20..0x7E (printable): WR_CHR at T+1 (char map write), WR_COL at T+2 (color map write, same be), then cursor advance and IDLE at T+3.
  - 0x0A (newline): col = 0, row + 1. No bus access.
  - 0x0D (carriage return): col = 0. No bus access.
  - 0x08 (backspace): col - 1 if col > 0, otherwise no change. No erase, no bus access.
  - 0x0C (form feed): full clear, then cursor = (0,0).
  - Any other code: dropped, cursor unchanged. Back to IDLE at T+1.
- Cursor advance: col + 1. When col reaches COLS, col = 0 and row + 1.
- Scroll: any row increment that would reach ROWS keeps row = ROWS-1 and starts a scroll.
  - Char map: for word w = 0 .. (ROWS-1)*COLS/4 - 1, SCR_RD reads word w + COLS/4, then SCR_WR writes word w with be = 4'hF.
  - Color map: same copy loop.
  - CLR then fills the last row: COLS/4 words of {4{BLANK}} in the char map and {4{color}} in the color map, with be = 4'hF.
  - Two cycles per copied word, one cycle per cleared word.
  - With defaults: 2*580*2 + 2*20 = 2360 cycles, then IDLE.
- Full clear (0x0C): CLR writes all ROWS*COLS/4 words in both maps, one word per cycle.
- ch_ready_o = 0 and busy_o = 1 in every state except IDLE. Characters arriving during a scroll or clear stay pending upstream.
- cursor_row_o and cursor_col_o update in the cycle the FSM returns to IDLE, or at T+1 for bus-less codes.

Test Plan:
- Reset, then send 'A' (0x41) with color 0x1F at cursor (0,0):
  - T+1: req=1, we=1, addr=CHAR_BASE, be=0001, wdata=0x41414141.
  - T+2: addr=COL_BASE, wdata=0x1F1F1F1F.
  - T+3: ready=1, cursor = (0,1).
- From cursor (2,5) send 'x':
  - idx = 165, addr = CHAR_BASE + 0xA4, be = 0010.
  - Then send 0x0D followed by 0x08: cursor = (2,0), stays (2,0), and no req.
- At (0,79) send 'z':
  - Write at idx 79, be = 1000.
  - Cursor wraps to (1,0).
- At row 29 send 0x0A (behavioural memory model preloaded with row-unique data):
  - Busy for 2360 cycles.
  - Row r now holds the old row r+1 in both maps.
  - Row 29 chars = 0x20, colors = the latched color.
  - Cursor = (29,0).
- Send 0x0C:
  - 600 + 600 consecutive single-cycle writes.
  - Cursor = (0,0).
  - ch_ready_o low throughout; a held ch_valid_i is accepted only after the clear ends.
- Assert rst_i mid-scroll:
  - req_o = 0 the next cycle.
  - Cursor = (0,0), ch_ready_o = 1 after release.
  - Send 0x07: dropped, no bus activity.
